uart_echo_engine: RTL
=====================

// Module: uart_echo_engine
// PURPOSE
//  Parametrised byte-stream engine between UART_Receiver and UART_Transmitter. Buffers received
//  bytes in an internal FIFO of configurable depth and re-emits them with a selectable transform:
//  plain echo, case swap, hex dump or CR->CRLF. It paces the transmitter with a dv/done handshake.
//  It also keeps overflow and traffic counters for the 7-seg/LED/PMOD debug.
// PARAMETERS
//  DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 bytes
//  COUNT_W     16  width of rx/tx byte counters
// PORTS
//  i_clk             in   1             system clock
//  i_rst             in   1             synchronous reset, active-high
//  i_rx_byte         in   8             received byte, valid with i_rx_valid
//  i_rx_valid        in   1             one-cycle strobe from receiver
//  i_mode            in   2             0 echo, 1 case swap, 2 hex dump, 3 CR->CRLF
//  i_tx_active       in   1             transmitter busy
//  i_tx_done         in   1             one-cycle strobe, transmitter finished a byte
//  i_clear_overflow  in   1             clears o_overflow
//  o_tx_byte         out  8             byte to transmit; stable from dv until done
//  o_tx_dv           out  1             one-cycle start strobe to transmitter
//  o_fifo_count      out  DEPTH_LOG2+1  bytes currently buffered
//  o_fifo_empty      out  1             o_fifo_count == 0
//  o_fifo_full       out  1             o_fifo_count == 2**DEPTH_LOG2
//  o_overflow        out  1             sticky: a byte was dropped
//  o_rx_count        out  COUNT_W       accepted bytes, wraps modulo 2**COUNT_W
//  o_tx_count        out  COUNT_W       transmitted chars (done strobes in WAIT), wraps
// BEHAVIOUR
//  Reset: state IDLE, FIFO emptied, o_fifo_empty=1, all other outputs 0, in-flight expansion dropped.
//  FIFO push:
//   - Push when i_rx_valid && (!full || pop this cycle).
//   - Otherwise drop the byte and set o_overflow.
//   - Set wins over i_clear_overflow in the same cycle.
//   - Push+pop in one cycle leaves the count unchanged.
//   - Pointers wrap modulo depth.
//  FSM states:
//   - IDLE:
//     - Go to POP when !o_fifo_empty && !i_tx_active.
//     - On that transition, latch the head byte into r_cur and i_mode into r_mode.
//     - Set char index k=0.
//     - Mode changes after this latch never affect the current byte.
//   - POP: advance the read pointer. Go to EMIT.
//   - EMIT: drive o_tx_byte=char(k) and o_tx_dv=1 for exactly 1 cycle. Go to WAIT.
//   - WAIT:
//     - On i_tx_done: o_tx_count++.
//     - If k < last char index, k++ and go to EMIT; else go to IDLE.
//     - i_tx_done seen outside WAIT is ignored.
//  Expansion (chars per byte):
//   - mode0: 1 char, the byte unchanged.
//   - mode1: 1 char. 0x41-0x5A and 0x61-0x7A are XORed with 0x20; all other bytes unchanged.
//   - mode2: 3 chars: ASCII hex of the high nibble, then the low nibble, then 0x20.
//     Hex digits are uppercase 0-9, A-F.
//   - mode3: 0x0D gives 0x0D then 0x0A; any other byte is 1 char, unchanged.
//  Latency: i_rx_valid at cycle N, engine idle, transmitter idle:
//   - count updates at N+1.
//   - IDLE->POP at N+1.
//   - o_tx_dv at N+3.
//  o_tx_byte holds its value from EMIT until the next EMIT; it returns to 0 only on reset.
//  Reset mid-expansion: remaining chars are lost. A late i_tx_done after reset is ignored.
// TESTING
//  T1 reset:
//   - stimulus: mode0, push 0x41.
//   - response: dv at N+3 with 0x41; rx_count=1, then tx_count=1 after done.
//  T2 case swap:
//   - stimulus: mode1, push "aZ5".
//   - response: tx sequence 0x41,0x7A,0x35.
//  T3 hex dump:
//   - stimulus: mode2, push 0x3C.
//   - response: 0x33,0x43,0x20; exactly 3 dv pulses, tx_count=3.
//  T4 CRLF:
//   - stimulus: mode3, push 0x0D,0x61.
//   - response: 0x0D,0x0A,0x61.
//   - stimulus: change i_mode to 0 while 0x0A is pending.
//   - response: still sends 0x0A.
//  T5 overflow:
//   - stimulus: DEPTH_LOG2=2, hold i_tx_active=1, push 6 bytes.
//   - response: count=4, full=1, overflow=1, rx_count=4.
//   - stimulus: clear_overflow.
//   - response: overflow=0.
//   - stimulus: clear + drop in the same cycle.
//   - response: overflow=1.
//  T6 wrap/reset:
//   - stimulus: push 20 bytes through DEPTH_LOG2=2 with a busy-paced tx model.
//   - response: output order matches input.
//   - stimulus: i_rst mid-WAIT.
//   - response: FSM in IDLE, empty=1, counters 0, stray done ignored.

Source files
------------

// File: rtl/uart_echo_engine.sv
// uart_echo_engine
// Sits between the UART receiver and transmitter. Received bytes are queued in a
// small FIFO. Each byte is then expanded into one to three characters depending on
// the transform mode and handed to the transmitter one character at a time using
// a dv/done handshake. Overflow and traffic counters feed the debug displays.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a buffered byte and an idle transmitter
// POP   | head byte already latched; retire it from the FIFO
// EMIT  | o_tx_dv is high for this single cycle with the current character
// WAIT  | waiting for the transmitter's done strobe for that character
module uart_echo_engine #(
    parameter int DEPTH_LOG2 = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_rx_valid,
    input  logic [1:0]            i_mode,
    input  logic                  i_tx_active,
    input  logic                  i_tx_done,
    input  logic                  i_clear_overflow,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_dv,
    output logic [DEPTH_LOG2:0]   o_fifo_count,
    output logic                  o_fifo_empty,
    output logic                  o_fifo_full,
    output logic                  o_overflow,
    output logic [COUNT_W-1:0]    o_rx_count,
    output logic [COUNT_W-1:0]    o_tx_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [COUNT_W-1:0]    TRAF_ONE  = 1;

    localparam logic [1:0] MODE_ECHO = 2'd0;
    localparam logic [1:0] MODE_SWAP = 2'd1;
    localparam logic [1:0] MODE_HEX  = 2'd2;
    localparam logic [1:0] MODE_CRLF = 2'd3;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        EMIT = 2'd2,
        WAIT = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  overflow_q;
    logic [COUNT_W-1:0]    rx_count_q;

    // Engine state
    state_t                state_q;
    logic [7:0]            cur_q;
    logic [1:0]            mode_q;
    logic [1:0]            k_q;
    logic [7:0]            tx_byte_q;
    logic                  tx_dv_q;
    logic [COUNT_W-1:0]    tx_count_q;

    logic                  full_d;
    logic                  empty_d;
    logic                  pop_d;
    logic                  push_d;
    logic [1:0]            last_k_d;
    logic [1:0]            next_k_d;
    logic [7:0]            char_cur_d;
    logic [7:0]            char_next_d;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_digit(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = {4'h3, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    // Character number k of the expansion of byte b under mode m.
    function automatic logic [7:0] char_of(input logic [7:0] b,
                                           input logic [1:0] m,
                                           input logic [1:0] k);
        logic [7:0] c;
        c = b;
        case (m)
            MODE_SWAP: begin
                if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
                    c = b ^ 8'h20;
                end
            end
            MODE_HEX: begin
                case (k)
                    2'd0:    c = hex_digit(b[7:4]);
                    2'd1:    c = hex_digit(b[3:0]);
                    default: c = CHAR_SPACE;
                endcase
            end
            MODE_CRLF: begin
                // Only a CR ever reaches k=1; its second character is the LF.
                if (k == 2'd1) begin
                    c = CHAR_LF;
                end
            end
            default: c = b;
        endcase
        return c;
    endfunction

    // FIFO status, push/pop decisions and expansion lookups
    always_comb begin
        empty_d  = (count_q == '0);
        // The count never exceeds DEPTH, so its MSB alone marks the full condition.
        full_d   = count_q[DEPTH_LOG2];
        pop_d    = (state_q == POP);
        // A full FIFO still accepts a byte in the cycle the head is retired.
        push_d   = i_rx_valid && (!full_d || pop_d);

        case ({push_d, pop_d})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (mode_q)
            MODE_HEX:  last_k_d = 2'd2;
            MODE_CRLF: last_k_d = (cur_q == CHAR_CR) ? 2'd1 : 2'd0;
            default:   last_k_d = 2'd0;
        endcase

        next_k_d    = k_q + 2'd1;
        char_cur_d  = char_of(cur_q, mode_q, k_q);
        char_next_d = char_of(cur_q, mode_q, next_k_d);
    end

    // FIFO data array; no reset needed since count gates every read
    always_ff @(posedge i_clk) begin
        if (push_d) begin
            mem_q[wr_ptr_q] <= i_rx_byte;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and accepted-byte counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rx_count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push_d) begin
                wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                rx_count_q <= rx_count_q + TRAF_ONE;
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (i_rx_valid && !push_d) begin
                overflow_q <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Sequencing FSM with registered transmitter outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            mode_q     <= MODE_ECHO;
            k_q        <= '0;
            tx_byte_q  <= '0;
            tx_dv_q    <= 1'b0;
            tx_count_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty_d && !i_tx_active) begin
                        // Byte and mode are frozen here for the whole expansion.
                        cur_q   <= mem_q[rd_ptr_q];
                        mode_q  <= i_mode;
                        k_q     <= '0;
                        state_q <= POP;
                    end
                end
                POP: begin
                    tx_byte_q <= char_cur_d;
                    tx_dv_q   <= 1'b1;
                    state_q   <= EMIT;
                end
                EMIT: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (i_tx_done) begin
                        tx_count_q <= tx_count_q + TRAF_ONE;
                        if (k_q < last_k_d) begin
                            k_q       <= next_k_d;
                            tx_byte_q <= char_next_d;
                            tx_dv_q   <= 1'b1;
                            state_q   <= EMIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_byte    = tx_byte_q;
    assign o_tx_dv      = tx_dv_q;
    assign o_fifo_count = count_q;
    assign o_fifo_empty = empty_d;
    assign o_fifo_full  = full_d;
    assign o_overflow   = overflow_q;
    assign o_rx_count   = rx_count_q;
    assign o_tx_count   = tx_count_q;

endmodule
